// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (IF) and
// data access (MEM): one access at a time, fixed latency, one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_IF,
  output logic              stall_MEM,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              acc_we_q, acc_we_d;
  logic [2:0]        lat_q, lat_d;
  logic [1:0]        if_denied_q, if_denied_d;
  logic [15:0]       conflict_q, conflict_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic              mem_wins;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    acc_we_d    = acc_we_q;
    lat_d       = lat_q;
    if_denied_d = if_denied_q;
    conflict_d  = conflict_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    // IF is forced through after losing two arbitrations in a row
    mem_wins    = mem_req && !(if_req && (if_denied_q == 2'd2));

    case (state_q)
      IDLE: begin
        if (mem_wins) begin
          state_d     = ACCESS;
          owner_d     = OWN_MEM;
          acc_we_d    = mem_we;
          lat_d       = LAT_INIT;
          ram_en_d    = 1'b1;
          ram_we_d    = mem_we;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata;
          if (if_req) begin
            if_denied_d = if_denied_q + 2'd1;
            if (conflict_q != 16'hFFFF) conflict_d = conflict_q + 16'd1;
          end
        end else if (if_req) begin
          state_d     = ACCESS;
          owner_d     = OWN_IF;
          acc_we_d    = 1'b0;
          lat_d       = LAT_INIT;
          if_denied_d = '0;
          ram_en_d    = 1'b1;
          ram_addr_d  = if_addr;
          ram_wdata_d = '0;
        end
      end
      ACCESS: begin
        if (lat_q == 3'd0) begin
          state_d = DONE;
          if (owner_q == OWN_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = ram_rdata;
          end else begin
            mem_ready_d = 1'b1;
            if (!acc_we_q) mem_rdata_d = ram_rdata;
          end
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      acc_we_q    <= 1'b0;
      lat_q       <= '0;
      if_denied_q <= '0;
      conflict_q  <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      acc_we_q    <= acc_we_d;
      lat_q       <= lat_d;
      if_denied_q <= if_denied_d;
      conflict_q  <= conflict_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  assign ram_en       = ram_en_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign if_rdata     = if_rdata_q;
  assign mem_rdata    = mem_rdata_q;
  assign if_ready     = if_ready_q;
  assign mem_ready    = mem_ready_q;
  assign conflict_cnt = conflict_q;
  assign stall_IF     = if_req & ~if_ready_q;
  assign stall_MEM    = mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each fed by a RAM stand-in that drives valid data only in the cycle it must be sampled.
module tb_mem_port_arbiter;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic        clk, rst;
  int unsigned checks = 0;
  int unsigned errors = 0;

  logic        a_if_req, a_if_ready, a_mem_req, a_mem_we, a_mem_ready;
  logic [31:0] a_if_addr, a_if_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_ram_en, a_ram_we, a_stall_if, a_stall_mem;
  logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata, a_word;
  logic [15:0] a_conflict;
  logic        a_pipe;

  logic        b_if_req, b_if_ready, b_mem_req, b_mem_we, b_mem_ready;
  logic [31:0] b_if_addr, b_if_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_ram_en, b_ram_we, b_stall_if, b_stall_mem;
  logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata, b_word;
  logic [15:0] b_conflict;
  logic [2:0]  b_pipe;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .mem_ready(a_mem_ready),
    .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
    .ram_rdata(a_ram_rdata), .stall_IF(a_stall_if), .stall_MEM(a_stall_mem),
    .conflict_cnt(a_conflict)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .ram_rdata(b_ram_rdata), .stall_IF(b_stall_if), .stall_MEM(b_stall_mem),
    .conflict_cnt(b_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM data is valid only MEM_LAT cycles after the ram_en cycle
  always @(posedge clk) begin
    a_pipe <= a_ram_en;
    b_pipe <= {b_pipe[1:0], b_ram_en};
  end
  assign a_ram_rdata = a_pipe    ? a_word : JUNK;
  assign b_ram_rdata = b_pipe[2] ? b_word : JUNK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic skip(input int unsigned n);
    repeat (n) next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_if_req = 0; a_if_addr = '0; a_mem_req = 0; a_mem_we = 0; a_mem_addr = '0; a_mem_wdata = '0;
    b_if_req = 0; b_if_addr = '0; b_mem_req = 0; b_mem_we = 0; b_mem_addr = '0; b_mem_wdata = '0;
    a_word = '0; b_word = '0; a_pipe = 0; b_pipe = '0;
    skip(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ram_en", a_ram_en, 0);
    chk("rst_ram_addr", a_ram_addr, 0);
    chk("rst_if_ready", a_if_ready, 0);
    chk("rst_conflict", a_conflict, 0);
    chk("rst_stall_if", a_stall_if, 0);

    // single fetch
    next_cycle(); a_if_req = 1; a_if_addr = 32'h40; a_word = 32'h2008_0005;
    @(negedge clk);
    chk("f_T_stall", a_stall_if, 1);
    chk("f_T_en", a_ram_en, 0);
    next_cycle(); @(negedge clk);
    chk("f_T1_en", a_ram_en, 1);
    chk("f_T1_we", a_ram_we, 0);
    chk("f_T1_addr", a_ram_addr, 32'h40);
    next_cycle(); @(negedge clk);
    chk("f_T2_en", a_ram_en, 0);
    chk("f_T2_ready", a_if_ready, 0);
    chk("f_T2_stall", a_stall_if, 1);
    next_cycle(); @(negedge clk);
    chk("f_T3_ready", a_if_ready, 1);
    chk("f_T3_rdata", a_if_rdata, 32'h2008_0005);
    chk("f_T3_stall", a_stall_if, 0);
    next_cycle(); a_if_req = 0;
    @(negedge clk);
    chk("f_T4_ready", a_if_ready, 0);

    // load, then store that must leave mem_rdata alone
    next_cycle(); a_mem_req = 1; a_mem_we = 0; a_mem_addr = 32'h104; a_word = 32'h1234_5678;
    skip(3); @(negedge clk);
    chk("ld_ready", a_mem_ready, 1);
    chk("ld_rdata", a_mem_rdata, 32'h1234_5678);
    next_cycle(); a_mem_req = 0;
    next_cycle(); a_mem_req = 1; a_mem_we = 1; a_mem_addr = 32'h100; a_mem_wdata = 32'hDEAD_BEEF;
    a_word = 32'hCAFE_F00D;
    @(negedge clk);
    chk("st_T_stall", a_stall_mem, 1);
    next_cycle(); @(negedge clk);
    chk("st_T1_en", a_ram_en, 1);
    chk("st_T1_we", a_ram_we, 1);
    chk("st_T1_addr", a_ram_addr, 32'h100);
    chk("st_T1_wdata", a_ram_wdata, 32'hDEAD_BEEF);
    next_cycle(); @(negedge clk);
    chk("st_T2_we", a_ram_we, 0);
    next_cycle(); @(negedge clk);
    chk("st_T3_ready", a_mem_ready, 1);
    chk("st_T3_rdata", a_mem_rdata, 32'h1234_5678);
    chk("st_T3_stall", a_stall_mem, 0);
    next_cycle(); a_mem_req = 0; a_mem_we = 0;

    // conflict: MEM first, IF in the following IDLE cycle
    next_cycle(); a_if_req = 1; a_if_addr = 32'h44; a_mem_req = 1; a_mem_addr = 32'h200;
    a_word = 32'h1111_0000;
    next_cycle(); @(negedge clk);
    chk("c_T1_addr", a_ram_addr, 32'h200);
    chk("c_T1_cnt", a_conflict, 1);
    chk("c_T1_stall_if", a_stall_if, 1);
    skip(2); @(negedge clk);
    chk("c_T3_mready", a_mem_ready, 1);
    chk("c_T3_iready", a_if_ready, 0);
    chk("c_T3_rdata", a_mem_rdata, 32'h1111_0000);
    next_cycle(); a_mem_req = 0; a_word = 32'h2222_0000;
    next_cycle(); @(negedge clk);
    chk("c_T5_en", a_ram_en, 1);
    chk("c_T5_addr", a_ram_addr, 32'h44);
    skip(2); @(negedge clk);
    chk("c_T7_iready", a_if_ready, 1);
    chk("c_T7_rdata", a_if_rdata, 32'h2222_0000);
    chk("c_T7_cnt", a_conflict, 1);
    next_cycle(); a_if_req = 0;

    // starvation guard: MEM twice, then IF despite mem_req
    next_cycle(); a_if_req = 1; a_if_addr = 32'h48; a_mem_req = 1; a_mem_addr = 32'h300;
    a_word = 32'h3333_0000;
    next_cycle(); @(negedge clk);
    chk("s_g1_addr", a_ram_addr, 32'h300);
    chk("s_g1_cnt", a_conflict, 2);
    skip(3); a_mem_addr = 32'h304;
    next_cycle(); @(negedge clk);
    chk("s_g2_addr", a_ram_addr, 32'h304);
    chk("s_g2_cnt", a_conflict, 3);
    skip(2); @(negedge clk);
    chk("s_g2_ready", a_mem_ready, 1);
    next_cycle(); a_word = 32'h4444_0000;
    next_cycle(); @(negedge clk);
    chk("s_g3_en", a_ram_en, 1);
    chk("s_g3_addr", a_ram_addr, 32'h48);
    chk("s_g3_cnt", a_conflict, 3);
    chk("s_g3_stall_mem", a_stall_mem, 1);
    skip(2); @(negedge clk);
    chk("s_g3_iready", a_if_ready, 1);
    chk("s_g3_mready", a_mem_ready, 0);
    chk("s_g3_rdata", a_if_rdata, 32'h4444_0000);
    next_cycle(); a_if_req = 0; a_mem_addr = 32'h308;
    next_cycle(); @(negedge clk);
    chk("s_g4_addr", a_ram_addr, 32'h308);
    chk("s_g4_cnt", a_conflict, 3);
    skip(2); @(negedge clk);
    chk("s_g4_ready", a_mem_ready, 1);
    next_cycle(); a_mem_req = 0;

    // MEM_LAT=3 load
    next_cycle(); b_mem_req = 1; b_mem_addr = 32'h500; b_word = 32'h6666_0000;
    next_cycle(); @(negedge clk);
    chk("l3_T1_en", b_ram_en, 1);
    chk("l3_T1_addr", b_ram_addr, 32'h500);
    for (int unsigned i = 2; i <= 4; i++) begin
      next_cycle(); @(negedge clk);
      chk("l3_en_low", b_ram_en, 0);
      chk("l3_ready_low", b_mem_ready, 0);
    end
    next_cycle(); @(negedge clk);
    chk("l3_T5_ready", b_mem_ready, 1);
    chk("l3_T5_rdata", b_mem_rdata, 32'h6666_0000);
    next_cycle(); b_mem_req = 0;
    @(negedge clk);
    chk("l3_T6_ready", b_mem_ready, 0);

    // reset in the first ACCESS cycle, then a fresh fetch
    next_cycle(); a_if_req = 1; a_if_addr = 32'h80; a_word = 32'h5555_0000;
    next_cycle(); rst = 1;
    @(negedge clk);
    chk("r_T1_en", a_ram_en, 1);
    next_cycle(); rst = 0; a_if_addr = 32'h84;
    @(negedge clk);
    chk("r_en", a_ram_en, 0);
    chk("r_addr", a_ram_addr, 0);
    chk("r_if_rdata", a_if_rdata, 0);
    chk("r_mem_rdata", a_mem_rdata, 0);
    chk("r_cnt", a_conflict, 0);
    chk("r_b_mem_rdata", b_mem_rdata, 0);
    next_cycle(); @(negedge clk);
    chk("r_T3_en", a_ram_en, 1);
    chk("r_T3_addr", a_ram_addr, 32'h84);
    chk("r_T3_ready", a_if_ready, 0);
    next_cycle(); @(negedge clk);
    chk("r_T4_ready", a_if_ready, 0);
    next_cycle(); @(negedge clk);
    chk("r_T5_ready", a_if_ready, 1);
    chk("r_T5_rdata", a_if_rdata, 32'h5555_0000);
    next_cycle(); a_if_req = 0;
    @(negedge clk);
    chk("r_T6_ready", a_if_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer sharing one single-port synchronous RAM between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the pipelined MIPS32 core. It resolves the resulting structural hazard by granting one access at a time through a small FSM and latency counter. It returns a one-cycle ready pulse with captured read data, and exports per-stage stall signals that the pipeline ORs into its existing stall/flush logic.

## Interface
- ADDR_W, 32, address width (byte address, passed through unchanged)
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from the ram_en cycle until ram_rdata is valid (legal range 1..7)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held high until if_ready
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_rdata  out  DATA_W  fetched instruction; valid when if_ready is high
- if_ready  out  1  one-cycle completion pulse for a fetch
- mem_req  in  1  data request; held high until mem_ready
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data; valid when mem_ready is high
- mem_ready  out  1  one-cycle completion pulse for a data access
- ram_en  out  1  RAM access strobe, registered
- ram_we  out  1  RAM write enable, registered, qualified by ram_en
- ram_addr  out  ADDR_W  RAM address, registered
- ram_wdata  out  DATA_W  RAM write data, registered
- ram_rdata  in  DATA_W  RAM read data
- stall_IF  out  1  combinational: if_req & ~if_ready
- stall_MEM  out  1  combinational: mem_req & ~mem_ready
- conflict_cnt  out  16  saturating count of cycles in which IF lost arbitration to MEM

## Operation
- FSM states: IDLE, ACCESS, DONE. Owner register: IF or MEM.
- IDLE arbitration:
  - If mem_req is high, MEM wins, unless the starvation guard is set.
  - Otherwise, if if_req is high, IF wins.
  - If neither is requesting, stay in IDLE.
- Starvation guard:
  - 2-bit counter `if_denied` increments on every IDLE decision where IF requested and lost.
  - When if_denied == 2 and if_req is high, IF wins regardless of mem_req.
  - if_denied clears on any IF grant.
- On grant:
  - Register ram_addr, ram_we (mem_we for MEM, 0 for IF) and ram_wdata (mem_wdata for MEM, 0 for IF).
  - Load the latency counter with MEM_LAT and go to ACCESS.
- ACCESS:
  - ram_en is high only in the first ACCESS cycle.
  - The counter decrements each cycle.
  - When the counter reaches 0, go to DONE. On a read, load ram_rdata into the owner's rdata register.
- DONE:
  - The owner's ready is high for exactly one cycle, then return to IDLE.
  - A request still high in the following IDLE cycle is treated as a new request.
- Stores do not modify mem_rdata. if_rdata and mem_rdata hold their values until the next read of the same owner.
- conflict_cnt increments in each IDLE cycle where if_req & mem_req are both high and MEM wins; it saturates at 16'hFFFF.
- Requester deasserting req mid-transaction is illegal. The access completes regardless and ready still pulses.

## Timing
- Reset (rst high at a clock edge), applied in any state including mid-access:
  - State returns to IDLE; the in-flight access is abandoned.
  - ram_en, ram_we, if_ready and mem_ready are 0.
  - ram_addr, ram_wdata, if_rdata and mem_rdata are 0.
  - if_denied and conflict_cnt are 0.
- Request first seen in IDLE in cycle T:
  - ram_en is high in cycle T+1.
  - ram_rdata is sampled at the end of cycle T+1+MEM_LAT.
  - ready is high in cycle T+2+MEM_LAT.
- Latency is 3 cycles for MEM_LAT=1. Back-to-back grants are MEM_LAT+3 cycles apart.
- Simultaneous if_req and mem_req in IDLE: MEM is granted and IF waits with stall_IF high. This is subject to the starvation guard.
- Ready pulses never overlap, and at most one ram_en pulse is in flight.

## Test plan
- Reset then single fetch (MEM_LAT=1): if_req=1, if_addr=0x0000_0040 at T, RAM returns 0x2008_0005 → ram_en=1, ram_we=0, ram_addr=0x40 at T+1; if_ready=1 with if_rdata=0x2008_0005 at T+3; stall_IF high T..T+2.
- Store: mem_req=1, mem_we=1, mem_addr=0x100, mem_wdata=0xDEAD_BEEF → ram_en=ram_we=1, ram_wdata=0xDEADBEEF at T+1; mem_ready at T+3; mem_rdata unchanged.
- Conflict: if_req and mem_req both high at T → MEM granted first, mem_ready at T+3; IF granted in the following IDLE cycle, if_ready at T+7; conflict_cnt=1.
- Starvation guard: mem_req re-asserted immediately after every mem_ready while if_req is held → MEM wins twice, IF wins the third arbitration; conflict_cnt=2.
- Latency parameter: MEM_LAT=3, single load → ready exactly 5 cycles after the request; ram_en high for exactly one cycle.
- Reset mid-access: rst in the first ACCESS cycle → next cycle is IDLE with all outputs 0; no ready pulse for the aborted access; a new fetch afterwards completes normally.
